// File: rtl/sva_ref_pkg.sv
// ---------------------------------------------------------------------------
// sva_ref_pkg
// Shared types and helpers for the sampled-value reference model.
//   sv_flags_t : packed bundle of the $rose/$fell/$stable results of a tick
//   DEF_CNT_W  : default width of the pass/fail scoreboard counters
//   sat_inc    : saturating increment, used so counters stick at all-ones
// ---------------------------------------------------------------------------
package sva_ref_pkg;

  typedef struct packed {
    logic rose;
    logic fell;
    logic stable;
  } sv_flags_t;

  localparam int DEF_CNT_W = 16;

  // Counters are at most 32 bits wide, so the increment is done at 32 bits
  // and the caller narrows the result back to its own width. maxVal is the
  // all-ones value of the caller's counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                          input logic [31:0] maxVal);
    return (cnt >= maxVal) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/sva_sample_history.sv
// ---------------------------------------------------------------------------
// sva_sample_history
// Tick-enabled history of the monitored signal plus the $past read mux.
//   i_clk, i_rst_n : clock (posedge) and asynchronous active-low reset
//   i_tick         : sampling tick qualifier
//   i_val          : value captured into slot 0 on a tick
//   i_past_sel     : history index; values at or beyond DEPTH read the oldest slot
//   o_last         : most recently sampled value (slot 0)
//   o_past_val     : slot selected by i_past_sel, purely from registered history
// ---------------------------------------------------------------------------
module sva_sample_history #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  localparam int SEL_W = $clog2(DEPTH) | 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic [WIDTH-1:0] i_val,
  input  logic [SEL_W-1:0] i_past_sel,
  output logic [WIDTH-1:0] o_last,
  output logic [WIDTH-1:0] o_past_val
);

  logic [WIDTH-1:0] r_hist [DEPTH];
  logic [WIDTH-1:0] w_pastVal;

  // Shift register of sampled values. Slot 0 holds the newest sample and
  // slot DEPTH-1 the oldest; everything clears to 0 on reset, which is what
  // makes the value "before the first sample" read as 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
    end else if (i_tick) begin
      r_hist[0] <= i_val;
      for (int i = 1; i < DEPTH; i++) r_hist[i] <= r_hist[i-1];
    end
  end

  // Read mux for $past. Defaulting to the oldest slot covers any select
  // value past the end of the history without a separate clamp stage.
  always_comb begin
    w_pastVal = r_hist[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      if (i_past_sel == SEL_W'(i)) w_pastVal = r_hist[i];
    end
  end

  assign o_last     = r_hist[0];
  assign o_past_val = w_pastVal;

endmodule

// File: rtl/sva_sampled_ref.sv
// ---------------------------------------------------------------------------
// sva_sampled_ref
// Plain-RTL golden model of $past/$rose/$fell/$stable and of the implication
// "ante |=> $rose(val)", scored once per sampling tick.
//   clk, rst_n  : sampling clock (posedge), asynchronous active-low reset
//   smp_en      : tick qualifier (tick = posedge clk with smp_en=1)
//   val, ante   : monitored signal and implication antecedent, sampled at ticks
//   past_sel    : $past depth select minus one
//   past_val    : history slot chosen by past_sel
//   rose/fell   : LSB edge of the last tick; stable compares the whole vector
//   chk_valid   : one-cycle pulse when an armed implication was evaluated
//   chk_fail    : one-cycle pulse, qualified by chk_valid, consequent false
//   pass_cnt/fail_cnt : saturating scoreboard counters
// ---------------------------------------------------------------------------
module sva_sampled_ref
  import sva_ref_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          smp_en,
  input  logic [WIDTH-1:0]              val,
  input  logic                          ante,
  input  logic [($clog2(DEPTH)|1)-1:0]  past_sel,
  output logic [WIDTH-1:0]              past_val,
  output logic                          rose,
  output logic                          fell,
  output logic                          stable,
  output logic                          chk_valid,
  output logic                          chk_fail,
  output logic [CNT_W-1:0]              pass_cnt,
  output logic [CNT_W-1:0]              fail_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONES = '1;

  logic [WIDTH-1:0] w_last;
  logic             w_roseNow;
  sv_flags_t        r_flags;
  logic             r_pend;
  logic             r_chkValid;
  logic             r_chkFail;
  logic [CNT_W-1:0] r_passCnt;
  logic [CNT_W-1:0] r_failCnt;

  sva_sample_history #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_history (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_tick     (smp_en),
    .i_val      (val),
    .i_past_sel (past_sel),
    .o_last     (w_last),
    .o_past_val (past_val)
  );

  // The implication consequent is $rose(val) evaluated at the same tick,
  // so a single term feeds both the rose flag and the checker.
  assign w_roseNow = val[0] & ~w_last[0];

  // Flags, implication state and scoreboard. chk_valid/chk_fail default low
  // every cycle so they stay one-cycle pulses. pend is rewritten on every
  // tick after the old value has been scored, which lets back-to-back
  // antecedents evaluate the previous one and arm the next in one tick.
  // Reset clears pend, so a check armed before reset is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags    <= '{rose: 1'b0, fell: 1'b0, stable: 1'b1};
      r_pend     <= 1'b0;
      r_chkValid <= 1'b0;
      r_chkFail  <= 1'b0;
      r_passCnt  <= '0;
      r_failCnt  <= '0;
    end else begin
      r_chkValid <= 1'b0;
      r_chkFail  <= 1'b0;
      if (smp_en) begin
        r_flags.rose   <= w_roseNow;
        r_flags.fell   <= ~val[0] & w_last[0];
        r_flags.stable <= (val == w_last);
        r_pend         <= ante;
        if (r_pend) begin
          r_chkValid <= 1'b1;
          r_chkFail  <= ~w_roseNow;
          if (w_roseNow)
            r_passCnt <= CNT_W'(sat_inc(32'(r_passCnt), 32'(CNT_ONES)));
          else
            r_failCnt <= CNT_W'(sat_inc(32'(r_failCnt), 32'(CNT_ONES)));
        end
      end
    end
  end

  assign rose      = r_flags.rose;
  assign fell      = r_flags.fell;
  assign stable    = r_flags.stable;
  assign chk_valid = r_chkValid;
  assign chk_fail  = r_chkFail;
  assign pass_cnt  = r_passCnt;
  assign fail_cnt  = r_failCnt;

endmodule

// File: tb/tb_sva_sampled_ref.sv
// ---------------------------------------------------------------------------
// tb_sva_sampled_ref
// Two instances share clock and reset: dutA (WIDTH=1, 16-bit counters) and
// dutB (WIDTH=8, 2-bit counters). A reference model keeps the full log of
// sampled values per instance and derives every expected output from it.
// ---------------------------------------------------------------------------
module tb_sva_sampled_ref;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;

  // dutA signals
  logic        smpEnA, valA, anteA;
  logic [2:0]  selA;
  logic        pastValA, roseA, fellA, stableA, chkValidA, chkFailA;
  logic [15:0] passCntA, failCntA;

  // dutB signals
  logic        smpEnB, anteB;
  logic [7:0]  valB;
  logic [2:0]  selB;
  logic [7:0]  pastValB;
  logic        roseB, fellB, stableB, chkValidB, chkFailB;
  logic [1:0]  passCntB, failCntB;

  int nCompared = 0;
  int nMismatch = 0;

  // Reference model state, index 0 = dutA, 1 = dutB
  logic [7:0] mLog [2][1024];
  int   mN    [2];
  bit   mPend [2];
  int   mPass [2];
  int   mFail [2];
  bit   eRose [2];
  bit   eFell [2];
  bit   eStable [2];
  bit   eChkV [2];
  bit   eChkF [2];
  int   cntMax [2] = '{65535, 3};
  logic [7:0] vMask [2] = '{8'h01, 8'hFF};

  always #5 clk = ~clk;

  sva_sampled_ref #(.WIDTH(1), .DEPTH(DEPTH), .CNT_W(16)) dutA (
    .clk(clk), .rst_n(rst_n), .smp_en(smpEnA), .val(valA), .ante(anteA),
    .past_sel(selA), .past_val(pastValA), .rose(roseA), .fell(fellA),
    .stable(stableA), .chk_valid(chkValidA), .chk_fail(chkFailA),
    .pass_cnt(passCntA), .fail_cnt(failCntA)
  );

  sva_sampled_ref #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .smp_en(smpEnB), .val(valB), .ante(anteB),
    .past_sel(selB), .past_val(pastValB), .rose(roseB), .fell(fellB),
    .stable(stableB), .chk_valid(chkValidB), .chk_fail(chkFailB),
    .pass_cnt(passCntB), .fail_cnt(failCntB)
  );

  // Forget everything sampled so far; the value before the first sample is 0.
  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mN[d] = 0; mPend[d] = 0; mPass[d] = 0; mFail[d] = 0;
      eRose[d] = 0; eFell[d] = 0; eStable[d] = 1; eChkV[d] = 0; eChkF[d] = 0;
    end
  endtask

  // Apply one clock of the specification's rules to instance d.
  task automatic modelClock(input int d, input logic en, input logic [7:0] v, input logic a);
    logic [7:0] cur, prev;
    bit consequent;
    eChkV[d] = 0;
    eChkF[d] = 0;
    if (!en) return;
    cur  = v & vMask[d];
    prev = (mN[d] == 0) ? 8'h00 : mLog[d][mN[d]-1];
    consequent = cur[0] && !prev[0];
    eRose[d]   = consequent;
    eFell[d]   = !cur[0] && prev[0];
    eStable[d] = (cur == prev);
    if (mPend[d]) begin
      eChkV[d] = 1;
      eChkF[d] = !consequent;
      if (consequent) begin
        if (mPass[d] < cntMax[d]) mPass[d]++;
      end else begin
        if (mFail[d] < cntMax[d]) mFail[d]++;
      end
    end
    mPend[d] = a;
    mLog[d][mN[d]] = cur;
    mN[d]++;
  endtask

  // $past(val, sel+1) from the log, selections beyond the history clamp to the oldest.
  function automatic logic [7:0] expPast(input int d, input logic [2:0] sel);
    int k;
    k = (int'(sel) > DEPTH-1) ? DEPTH-1 : int'(sel);
    return (k < mN[d]) ? mLog[d][mN[d]-1-k] : 8'h00;
  endfunction

  // One clock: inputs are set at a negedge, the posedge samples them and
  // outputs are checked at the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    modelClock(0, smpEnA, {7'b0, valA}, anteA);
    modelClock(1, smpEnB, valB, anteB);
  endtask

  task automatic applyReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus();
    smpEnA = 0; valA = 0; anteA = 0; selA = 0;
    smpEnB = 0; valB = 0; anteB = 0; selB = 0;
    rst_n  = 1'b1;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic test_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    nCompared++;
    if ({pastValA, roseA, fellA, stableA, chkValidA, chkFailA, passCntA, failCntA} !== {1'b0, 5'b00100, 32'd0}) begin
      nMismatch++;
      $display("[TB] FAIL reset_A got %h want %h",
               {pastValA, roseA, fellA, stableA, chkValidA, chkFailA, passCntA, failCntA}, {1'b0, 5'b00100, 32'd0});
    end
    nCompared++;
    if ({pastValB, roseB, fellB, stableB, chkValidB, chkFailB, passCntB, failCntB} !== {8'h00, 5'b00100, 4'd0}) begin
      nMismatch++;
      $display("[TB] FAIL reset_B got %h want %h",
               {pastValB, roseB, fellB, stableB, chkValidB, chkFailB, passCntB, failCntB}, {8'h00, 5'b00100, 4'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // val alternates starting at 1, antecedent on odd ticks: every check passes.
  task automatic test_alternating_pass();
    applyReset();
    smpEnA = 1;
    for (int t = 0; t < 12; t++) begin
      valA  = logic'(t % 2 == 0);
      anteA = logic'(t % 2 == 1);
      step();
      nCompared++;
      if (roseA !== logic'(t % 2 == 0)) begin
        nMismatch++;
        $display("[TB] FAIL alt_pass_rose t=%0d got %b want %b", t, roseA, t % 2 == 0);
      end
      nCompared++;
      if (chkFailA !== 1'b0) begin
        nMismatch++;
        $display("[TB] FAIL alt_pass_chkfail t=%0d got %b want 0", t, chkFailA);
      end
    end
    smpEnA = 0;
    nCompared++;
    if (passCntA !== 16'd5 || failCntA !== 16'd0) begin
      nMismatch++;
      $display("[TB] FAIL alt_pass_counts got %0d/%0d want 5/0", passCntA, failCntA);
    end
  endtask

  // Antecedent on even ticks: each is followed by a falling val, so every
  // check fails; antecedents at ticks 0..10 give six evaluations.
  task automatic test_alternating_fail();
    applyReset();
    smpEnA = 1;
    for (int t = 0; t < 12; t++) begin
      valA  = logic'(t % 2 == 0);
      anteA = logic'(t % 2 == 0);
      step();
      nCompared++;
      if (chkValidA !== logic'(t % 2 == 1) || chkFailA !== logic'(t % 2 == 1)) begin
        nMismatch++;
        $display("[TB] FAIL alt_fail_pulse t=%0d got %b%b want %b%b", t, chkValidA, chkFailA,
                 t % 2 == 1, t % 2 == 1);
      end
    end
    smpEnA = 0;
    nCompared++;
    if (passCntA !== 16'd0 || failCntA !== 16'(mFail[0])) begin
      nMismatch++;
      $display("[TB] FAIL alt_fail_counts got %0d/%0d want 0/%0d", passCntA, failCntA, mFail[0]);
    end
  endtask

  // Wide history: after 1..5 the history reads 5,4,3,2.
  task automatic test_past_history();
    applyReset();
    smpEnB = 1;
    for (int v = 1; v <= 5; v++) begin
      valB = 8'(v);
      step();
    end
    smpEnB = 0;
    selB = 3'd0; #1;
    nCompared++;
    if (pastValB !== 8'd5) begin
      nMismatch++; $display("[TB] FAIL past_sel0 got %0d want 5", pastValB);
    end
    selB = 3'd3; #1;
    nCompared++;
    if (pastValB !== 8'd2) begin
      nMismatch++; $display("[TB] FAIL past_sel3 got %0d want 2", pastValB);
    end
    selB = 3'd6; #1;
    nCompared++;
    if (pastValB !== 8'd2) begin
      nMismatch++; $display("[TB] FAIL past_clamp got %0d want 2", pastValB);
    end
    @(negedge clk);
    valB = 8'd5; smpEnB = 1;
    step();
    smpEnB = 0;
    nCompared++;
    if (stableB !== 1'b1) begin
      nMismatch++; $display("[TB] FAIL past_stable got %b want 1", stableB);
    end
  endtask

  // Gap of three non-tick clocks while val toggles: nothing may move.
  task automatic test_tick_gap();
    applyReset();
    smpEnA = 1; valA = 1; anteA = 1;
    step();
    smpEnA = 0;
    for (int g = 0; g < 3; g++) begin
      valA  = ~valA;
      anteA = 1'($urandom_range(0, 1));
      step();
      nCompared++;
      if ({roseA, fellA, stableA, chkValidA, passCntA, failCntA} !== {4'b1000, 32'd0}) begin
        nMismatch++;
        $display("[TB] FAIL gap_hold g=%0d got %h want %h", g,
                 {roseA, fellA, stableA, chkValidA, passCntA, failCntA}, {4'b1000, 32'd0});
      end
    end
    smpEnA = 1; valA = 1; anteA = 0;
    step();
    smpEnA = 0;
    nCompared++;
    if ({roseA, stableA, chkValidA, chkFailA} !== 4'b0111) begin
      nMismatch++;
      $display("[TB] FAIL gap_resume got %b want 0111", {roseA, stableA, chkValidA, chkFailA});
    end
  endtask

  // Reset while a check is pending drops it.
  task automatic test_reset_pending();
    applyReset();
    smpEnA = 1; valA = 0; anteA = 1;
    step();
    valA = 1;
    step();
    smpEnA = 0;
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    nCompared++;
    if ({roseA, stableA, passCntA} !== {2'b01, 16'd0}) begin
      nMismatch++;
      $display("[TB] FAIL rst_pend_clear got %h want %h", {roseA, stableA, passCntA}, {2'b01, 16'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    smpEnA = 1; valA = 1; anteA = 0;
    step();
    smpEnA = 0;
    nCompared++;
    if ({chkValidA, passCntA, failCntA} !== 33'd0) begin
      nMismatch++;
      $display("[TB] FAIL rst_pend_drop got %h want 0", {chkValidA, passCntA, failCntA});
    end
  endtask

  // 2-bit counters saturate; then LSB-only edge rules on a wide value.
  task automatic test_saturate_lsb();
    applyReset();
    smpEnB = 1; anteB = 1; valB = 8'h00;
    for (int t = 0; t < 6; t++) step();
    nCompared++;
    if (failCntB !== 2'd3 || chkFailB !== 1'b1) begin
      nMismatch++;
      $display("[TB] FAIL sat_fail got cnt=%0d pulse=%b want 3/1", failCntB, chkFailB);
    end
    anteB = 0; valB = 8'h03;
    step();
    valB = 8'h02;
    step();
    nCompared++;
    if ({roseB, fellB, stableB} !== 3'b010) begin
      nMismatch++; $display("[TB] FAIL lsb_03_02 got %b want 010", {roseB, fellB, stableB});
    end
    valB = 8'h06;
    step();
    smpEnB = 0;
    nCompared++;
    if ({roseB, fellB, stableB} !== 3'b000) begin
      nMismatch++; $display("[TB] FAIL lsb_02_06 got %b want 000", {roseB, fellB, stableB});
    end
  endtask

  // Random ticks, values, antecedents and selects on both instances.
  task automatic test_random();
    logic [7:0]  pA, pB;
    logic [37:0] obsA, expA;
    logic [16:0] obsB, expB;
    applyReset();
    for (int c = 0; c < 400; c++) begin
      smpEnA = logic'($urandom_range(0, 3) != 0);
      valA   = 1'($urandom_range(0, 1));
      anteA  = 1'($urandom_range(0, 1));
      selA   = 3'($urandom_range(0, 7));
      smpEnB = logic'($urandom_range(0, 3) != 0);
      valB   = 8'($urandom_range(0, 3));
      anteB  = 1'($urandom_range(0, 1));
      selB   = 3'($urandom_range(0, 7));
      step();
      pA = expPast(0, selA);
      pB = expPast(1, selB);
      obsA = {pastValA, roseA, fellA, stableA, chkValidA, chkFailA, passCntA, failCntA};
      expA = {pA[0], eRose[0], eFell[0], eStable[0], eChkV[0], eChkF[0], mPass[0][15:0], mFail[0][15:0]};
      obsB = {pastValB, roseB, fellB, stableB, chkValidB, chkFailB, passCntB, failCntB};
      expB = {pB, eRose[1], eFell[1], eStable[1], eChkV[1], eChkF[1], mPass[1][1:0], mFail[1][1:0]};
      nCompared++;
      if (obsA !== expA) begin
        nMismatch++; $display("[TB] FAIL random_A c=%0d got %h want %h", c, obsA, expA);
      end
      nCompared++;
      if (obsB !== expB) begin
        nMismatch++; $display("[TB] FAIL random_B c=%0d got %h want %h", c, obsB, expB);
      end
    end
    smpEnA = 0; smpEnB = 0;
  endtask

  // Directed scenarios first, then the randomized cross-check.
  initial begin
    applyStimulus();
    modelReset();
    test_reset();
    test_alternating_pass();
    test_alternating_fail();
    test_past_history();
    test_tick_gap();
    test_reset_pending();
    test_saturate_lsb();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
